// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared pointer-width helper and status struct for the fifo subsystem
package fifo_pkg;

  // Pointers carry one extra wrap bit above the entry index.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic overflow;
    logic underflow;
  } fifo_status_t;

endpackage

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - simple dual-port storage array; async read when SYNC_FIFO_FWFT_EN is defined
module fifo_mem #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  // Storage is deliberately left unreset.
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

`ifdef SYNC_FIFO_FWFT_EN
  logic unused_rd_ctrl;
  assign unused_rd_ctrl = rd_en ^ rst;
  assign rd_data        = mem_q[rd_addr];
`else
  logic [WIDTH-1:0] rd_data_q;
  logic [WIDTH-1:0] rd_data_d;

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) rd_data_d = mem_q[rd_addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_data_q <= '0;
    else     rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;
`endif

endmodule

// File: rtl/sync_fifo_ctrl.sv
// rtl/sync_fifo_ctrl.sv - single-clock FIFO with pointer/status/flag logic; SYNC_FIFO_FWFT_EN selects fall-through read
module sync_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int DEPTH        = 16,
  parameter int AFULL_THRESH = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  output logic                     full,
  output logic                     almost_full,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH)-1:0] wr_addr,
  output logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic                     wr_fire,
  output logic                     rd_fire,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int PTR_W  = ptr_width(DEPTH);
  localparam int ADDR_W = PTR_W - 1;
  localparam logic [PTR_W-1:0] AFULL_LVL = PTR_W'(AFULL_THRESH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic [PTR_W-1:0] occupancy;
  fifo_status_t     status;

  // Status is purely combinational from the registered pointers.
  always_comb begin
    occupancy          = wr_ptr_q - rd_ptr_q;
    status.empty       = (wr_ptr_q == rd_ptr_q);
    status.full        = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                         (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
    status.almost_full = (occupancy >= AFULL_LVL);
    status.overflow    = overflow_q;
    status.underflow   = underflow_q;
  end

  assign wr_fire = wr_en & ~status.full;
  assign rd_fire = rd_en & ~status.empty;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    overflow_d  = overflow_q  | (wr_en & status.full);
    underflow_d = underflow_q | (rd_en & status.empty);
    if (wr_fire) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (rd_fire) rd_ptr_d = rd_ptr_q + PTR_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign wr_addr     = wr_ptr_q[ADDR_W-1:0];
  assign rd_addr     = rd_ptr_q[ADDR_W-1:0];
  assign count       = occupancy;
  assign full        = status.full;
  assign empty       = status.empty;
  assign almost_full = status.almost_full;
  assign overflow    = status.overflow;
  assign underflow   = status.underflow;

`ifdef SYNC_FIFO_FWFT_EN
  assign rd_valid = ~status.empty;
`else
  logic rd_valid_q, rd_valid_d;

  always_comb begin
    rd_valid_d = rd_fire;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_valid_q <= 1'b0;
    else     rd_valid_q <= rd_valid_d;
  end

  assign rd_valid = rd_valid_q;
`endif

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_mem (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_fire),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .rd_en  (rd_fire),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// tb/tb_sync_fifo_ctrl.sv - directed self-checking bench for sync_fifo_ctrl (either SYNC_FIFO_FWFT_EN mode)
module tb_sync_fifo_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        full;
  logic        almost_full;
  logic        rd_en;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        empty;
  logic [4:0]  count;
  logic [3:0]  wr_addr;
  logic [3:0]  rd_addr;
  logic        wr_fire;
  logic        rd_fire;
  logic        overflow;
  logic        underflow;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] ref_q[$];
  logic [3:0]  exp_wa;
  logic [3:0]  exp_ra;

  always #5 clk = ~clk;

  sync_fifo_ctrl #(
    .WIDTH       (32),
    .DEPTH       (16),
    .AFULL_THRESH(12)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .full       (full),
    .almost_full(almost_full),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .empty      (empty),
    .count      (count),
    .wr_addr    (wr_addr),
    .rd_addr    (rd_addr),
    .wr_fire    (wr_fire),
    .rd_fire    (rd_fire),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
    cycle();
    rst = 1'b0;
    ref_q.delete();
    exp_wa = '0;
    exp_ra = '0;
  endtask

  task automatic push(input logic [31:0] d, input logic exp_fire);
    wr_en = 1'b1; wr_data = d; rd_en = 1'b0;
    #1;
    check_eq("wr_fire", wr_fire, exp_fire);
    if (exp_fire) begin
      check_eq("wr_addr", wr_addr, exp_wa);
      ref_q.push_back(d);
      exp_wa++;
    end
    cycle();
    wr_en = 1'b0;
    check_eq("count_after_wr", count, ref_q.size());
  endtask

  task automatic pop();
    logic [31:0] exp_d;
    exp_d = ref_q.pop_front();
`ifdef SYNC_FIFO_FWFT_EN
    check_eq("fwft_valid", rd_valid, 1'b1);
    check_eq("fwft_data", rd_data, exp_d);
`endif
    rd_en = 1'b1;
    #1;
    check_eq("rd_fire", rd_fire, 1'b1);
    check_eq("rd_addr", rd_addr, exp_ra);
    exp_ra++;
    cycle();
    rd_en = 1'b0;
`ifndef SYNC_FIFO_FWFT_EN
    check_eq("rd_valid", rd_valid, 1'b1);
    check_eq("rd_data", rd_data, exp_d);
`endif
    check_eq("count_after_rd", count, ref_q.size());
  endtask

  task automatic push_pop(input logic [31:0] d, input logic exp_wf, input logic exp_rf);
    logic [31:0] exp_d;
    wr_en = 1'b1; rd_en = 1'b1; wr_data = d;
    #1;
    check_eq("both_wr_fire", wr_fire, exp_wf);
    check_eq("both_rd_fire", rd_fire, exp_rf);
    exp_d = '0;
    if (exp_rf) begin
      exp_d = ref_q.pop_front();
`ifdef SYNC_FIFO_FWFT_EN
      check_eq("both_fwft_data", rd_data, exp_d);
`endif
      exp_ra++;
    end
    if (exp_wf) begin
      ref_q.push_back(d);
      exp_wa++;
    end
    cycle();
    wr_en = 1'b0; rd_en = 1'b0;
`ifndef SYNC_FIFO_FWFT_EN
    if (exp_rf) check_eq("both_rd_data", rd_data, exp_d);
`endif
    check_eq("both_count", count, ref_q.size());
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
    exp_wa = '0; exp_ra = '0;
    #1;
    check_eq("rst_empty", empty, 1'b1);
    check_eq("rst_full", full, 1'b0);
    check_eq("rst_afull", almost_full, 1'b0);
    check_eq("rst_count", count, 0);
    check_eq("rst_rd_valid", rd_valid, 1'b0);
`ifndef SYNC_FIFO_FWFT_EN
    check_eq("rst_rd_data", rd_data, 0);
`endif
    check_eq("rst_ovf", overflow, 1'b0);
    check_eq("rst_unf", underflow, 1'b0);
    check_eq("rst_wr_addr", wr_addr, 0);
    check_eq("rst_rd_addr", rd_addr, 0);
    do_reset();

    // Fill to full, then one rejected write.
    for (int i = 0; i < 16; i++) begin
      push(32'(i), 1'b1);
      check_eq("afull_fill", almost_full, (i + 1) >= 12);
      check_eq("full_fill", full, (i + 1) == 16);
    end
    push(32'h11, 1'b0);
    check_eq("overflow_set", overflow, 1'b1);
    check_eq("count_held", count, 16);

    // Drain in order, then one rejected read.
    for (int i = 0; i < 16; i++) pop();
    check_eq("drained_empty", empty, 1'b1);
    rd_en = 1'b1;
    #1;
    check_eq("empty_rd_fire", rd_fire, 1'b0);
    cycle();
    rd_en = 1'b0;
    check_eq("underflow_set", underflow, 1'b1);
    check_eq("empty_rd_valid", rd_valid, 1'b0);

    // Pointer wrap with reference queue.
    do_reset();
    for (int i = 0; i < 10; i++) push(32'h100 + 32'(i), 1'b1);
    for (int i = 0; i < 10; i++) pop();
    for (int i = 0; i < 10; i++) push(32'h200 + 32'(i), 1'b1);
    check_eq("wrap_wr_addr", wr_addr, 4'h4);
    check_eq("wrap_rd_addr", rd_addr, 4'hA);
    for (int i = 0; i < 10; i++) pop();
    check_eq("wrap_empty", empty, 1'b1);

    // Simultaneous traffic at count 5.
    do_reset();
    for (int i = 0; i < 5; i++) push(32'h300 + 32'(i), 1'b1);
    for (int i = 0; i < 20; i++) push_pop(32'h400 + 32'(i), 1'b1, 1'b1);
    check_eq("steady_count", count, 5);

    // Simultaneous at empty, then at full.
    do_reset();
    push_pop(32'h500, 1'b1, 1'b0);
    check_eq("emp_both_unf", underflow, 1'b1);
    check_eq("emp_both_ovf", overflow, 1'b0);
    for (int i = 1; i < 16; i++) push(32'h500 + 32'(i), 1'b1);
    check_eq("refill_full", full, 1'b1);
    push_pop(32'h5FF, 1'b0, 1'b1);
    check_eq("full_both_ovf", overflow, 1'b1);
    check_eq("full_both_count", count, 15);

    // Reset mid-stream at count 7 with a read in flight.
    for (int i = 0; i < 8; i++) pop();
    check_eq("pre_rst_count", count, 7);
    rd_en = 1'b1;
    #1;
    check_eq("inflight_rd_fire", rd_fire, 1'b1);
    rst = 1'b1;
    #1;
    check_eq("async_count", count, 0);
    cycle();
    check_eq("midrst_count", count, 0);
    check_eq("midrst_empty", empty, 1'b1);
    check_eq("midrst_rd_valid", rd_valid, 1'b0);
    check_eq("midrst_ovf", overflow, 1'b0);
    check_eq("midrst_unf", underflow, 1'b0);
    rst = 1'b0; rd_en = 1'b0;
    cycle();
    check_eq("post_rst_rd_valid", rd_valid, 1'b0);
    check_eq("post_rst_empty", empty, 1'b1);

    // Single word: fall-through visibility vs registered read.
    do_reset();
    push(32'hA5, 1'b1);
`ifdef SYNC_FIFO_FWFT_EN
    check_eq("fwft_a5_valid", rd_valid, 1'b1);
    check_eq("fwft_a5_data", rd_data, 32'hA5);
`else
    check_eq("reg_a5_no_valid", rd_valid, 1'b0);
`endif
    pop();
    check_eq("a5_empty", empty, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
